// File: rtl/swap_skid_stage_pkg.sv
// Shared definitions for swap_skid_stage: FSM state encoding and default sizes.
// The optional swap statistics output is enabled by defining SWAP_STATS_EN.
package swap_skid_stage_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/swap_skid_stage_pair_swap_reg.sv
// One operand-pair register with load enable; on load it optionally stores the
// pair exchanged. Both fields come from the same sampled sources, so no duplication.
module pair_swap_reg
   import swap_skid_stage_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             swap,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a <= '0;
         b <= '0;
      end else if (load) begin
         a <= swap ? src_b : src_a;
         b <= swap ? src_a : src_b;
      end
   end

endmodule

// File: rtl/swap_skid_stage.sv
// Operand-pair stage with optional A/B exchange behind a 2-entry skid buffer.
// Defining SWAP_STATS_EN adds the swap_count output and per-entry swap flags.
module swap_skid_stage
   import swap_skid_stage_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_swap,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [CNT_W-1:0] xfer_count
`ifdef SWAP_STATS_EN
   ,
   output logic [CNT_W-1:0] swap_count
`endif
);

   state_t             state_reg, state_next;
   logic               in_ready_reg;
   logic               out_valid_reg;
   logic [CNT_W-1:0]   xfer_count_reg;
   logic               accept, take;
   logic               main_load, main_from_skid, skid_load;
   logic [WIDTH-1:0]   skid_a, skid_b;
   logic [WIDTH-1:0]   main_src_a, main_src_b;
   logic               main_swap;

   assign accept = in_valid & in_ready_reg;
   assign take   = out_valid_reg & out_ready;

   always_comb begin
      state_next     = state_reg;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               state_next = ST_BUSY;
               main_load  = 1'b1;
            end
         end
         ST_BUSY: begin
            if (accept && take) begin
               main_load = 1'b1;
            end else if (accept) begin
               skid_load  = 1'b1;
               state_next = ST_FULL;
            end else if (take) begin
               state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (take) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               state_next     = ST_BUSY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // Skid contents are already in final order, so refilling main never re-swaps.
   assign main_src_a = main_from_skid ? skid_a : in_a;
   assign main_src_b = main_from_skid ? skid_b : in_b;
   assign main_swap  = main_from_skid ? 1'b0 : in_swap;

   pair_swap_reg #(.WIDTH(WIDTH)) u_main (
      .clock (clock),
      .reset (reset),
      .load  (main_load),
      .swap  (main_swap),
      .src_a (main_src_a),
      .src_b (main_src_b),
      .a     (out_a),
      .b     (out_b)
   );

   pair_swap_reg #(.WIDTH(WIDTH)) u_skid (
      .clock (clock),
      .reset (reset),
      .load  (skid_load),
      .swap  (in_swap),
      .src_a (in_a),
      .src_b (in_b),
      .a     (skid_a),
      .b     (skid_b)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_EMPTY;
         in_ready_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         xfer_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         in_ready_reg  <= (state_next != ST_FULL);
         out_valid_reg <= (state_next != ST_EMPTY);
         if (take) begin
            xfer_count_reg <= xfer_count_reg + CNT_W'(1);
         end
      end
   end

   assign in_ready   = in_ready_reg;
   assign out_valid  = out_valid_reg;
   assign xfer_count = xfer_count_reg;

`ifdef SWAP_STATS_EN
   logic             main_swapped_reg;
   logic             skid_swapped_reg;
   logic [CNT_W-1:0] swap_count_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_swapped_reg <= 1'b0;
         skid_swapped_reg <= 1'b0;
         swap_count_reg   <= '0;
      end else begin
         if (main_load) begin
            main_swapped_reg <= main_from_skid ? skid_swapped_reg : in_swap;
         end
         if (skid_load) begin
            skid_swapped_reg <= in_swap;
         end
         if (take && main_swapped_reg) begin
            swap_count_reg <= swap_count_reg + CNT_W'(1);
         end
      end
   end

   assign swap_count = swap_count_reg;
`endif

endmodule

// File: tb/tb_swap_skid_stage.sv
// Scoreboard bench for swap_skid_stage: the driver pushes expected pairs, a
// negedge monitor pops and compares on every output handshake.
module tb_swap_skid_stage;

   localparam int W = 16;
   localparam int C = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_swap = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_b;
   logic [C-1:0]  xfer_count;
`ifdef SWAP_STATS_EN
   logic [C-1:0]  swap_count;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clock = ~clock;

   swap_skid_stage #(.WIDTH(W), .CNT_W(C)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_swap    (in_swap),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_a      (out_a),
      .out_b      (out_b),
      .xfer_count (xfer_count)
`ifdef SWAP_STATS_EN
      ,
      .swap_count (swap_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issue one pair; returns #1 after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sw);
      int n;
      in_a = a; in_b = b; in_swap = sw; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clock);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'(n), 32'd0);
            break;
         end
      end
      exp_q.push_back(sw ? {b, a} : {a, b});
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {out_a, out_b}, 32'hxxxxxxxx);
         end else begin
            chk("out_pair", {out_a, out_b}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset release
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_xfer", 32'(xfer_count), 32'd0);
      chk("rst_out_pair", {out_a, out_b}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("pre_edge_in_ready", 32'(in_ready), 32'd0);
      @(posedge clock);
      #1;
      chk("post_edge_in_ready", 32'(in_ready), 32'd1);

      // swap
      out_ready = 1'b1;
      send(16'h1234, 16'hABCD, 1'b1);
      chk("swap_valid", 32'(out_valid), 32'd1);
      chk("swap_pair", {out_a, out_b}, 32'hABCD1234);
      @(posedge clock);
      #1;
      chk("swap_xfer", 32'(xfer_count), 32'd1);
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_hold", {out_a, out_b}, 32'hABCD1234);
`ifdef SWAP_STATS_EN
      chk("swap_cnt_1", 32'(swap_count), 32'd1);
`endif

      // back-pressure fills skid
      out_ready = 1'b0;
      send(16'd1, 16'd2, 1'b0);
      send(16'd3, 16'd4, 1'b0);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_hold", {out_a, out_b}, {16'd1, 16'd2});
      repeat (2) @(posedge clock);
      #1;
      chk("stall_stable", {out_a, out_b}, {16'd1, 16'd2});
      chk("stall_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("drain_xfer", 32'(xfer_count), 32'd3);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // streaming, alternating swap
      for (int i = 0; i < 10; i++) begin
         chk("stream_in_ready", 32'(in_ready), 32'd1);
         send(W'(16 + 2 * i), W'(17 + 2 * i), i[0]);
         chk("stream_latency", 32'(out_valid), 32'd1);
      end
      @(posedge clock);
      #1;
      chk("stream_xfer", 32'(xfer_count), 32'd13);
`ifdef SWAP_STATS_EN
      chk("swap_cnt_6", 32'(swap_count), 32'd6);
`endif

      // preload up to the wrap point
      for (int i = 0; i < 65522; i++) begin
         send(W'(i), ~W'(i), 1'b0);
      end
      @(posedge clock);
      #1;
      chk("xfer_ffff", 32'(xfer_count), 32'h0000FFFF);
      send(16'hAAAA, 16'h5555, 1'b1);
      @(posedge clock);
      #1;
      chk("xfer_wrap", 32'(xfer_count), 32'd0);
`ifdef SWAP_STATS_EN
      chk("swap_cnt_7", 32'(swap_count), 32'd7);
`endif

      // asynchronous reset while FULL
      out_ready = 1'b0;
      send(16'd5, 16'd6, 1'b1);
      send(16'd7, 16'd8, 1'b0);
      chk("mid_full", 32'(in_ready), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_in_ready", 32'(in_ready), 32'd0);
      chk("async_xfer", 32'(xfer_count), 32'd0);
      chk("async_pair", {out_a, out_b}, 32'd0);
`ifdef SWAP_STATS_EN
      chk("async_swap_cnt", 32'(swap_count), 32'd0);
`endif
      exp_q.delete();
      @(negedge clock);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      chk("no_stale_valid", 32'(out_valid), 32'd0);
      send(16'd9, 16'd10, 1'b0);
      @(posedge clock);
      #1;
      chk("post_rst_xfer", 32'(xfer_count), 32'd1);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
